// File: rtl/sd_sector_sequencer.sv
// sd_sector_sequencer: runs a multi-sector read on SDReader one transaction at a
// time. Each sector waits for downstream room and an idle reader, then holds
// rstart until rdone. Every sector's byte count is checked, and a card that stalls
// is cut off after a cycle budget. The sequence can be aborted at any point.
`timescale 1ns/1ps
module sd_sector_sequencer #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] first_sector,
    input  logic [15:0] num_sectors,
    input  logic        sink_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] sectors_done,
    output logic        rstart,
    output logic [31:0] rsector_no,
    input  logic        rbusy,
    input  logic        rdone,
    input  logic        outreq
);

    localparam logic [15:0] SECTOR_BYTES_C = 16'(SECTOR_BYTES);
    localparam logic [31:0] TMO_LAST       = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST       = 16'(GAP_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_COUNT   = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SINK,
        S_ISSUE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t      state;
    logic [31:0] cur_sector;
    logic [15:0] remaining;
    logic [15:0] byte_cnt;
    logic [31:0] tmo_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] byte_now;

    // Byte counter step that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic inc);
        if (!inc || val == 16'hFFFF)
            return val;
        return val + 16'd1;
    endfunction

    // The byte count includes an outreq that lands in the same cycle as rdone.
    assign byte_now = sat_inc(byte_cnt, outreq);

    // Sequencer FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            sectors_done <= 16'd0;
            rstart       <= 1'b0;
            rsector_no   <= 32'd0;
            cur_sector   <= 32'd0;
            remaining    <= 16'd0;
            byte_cnt     <= 16'd0;
            tmo_cnt      <= 32'd0;
            gap_cnt      <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_sector   <= first_sector;
                        remaining    <= num_sectors;
                        error        <= 1'b0;
                        err_code     <= ERR_NONE;
                        sectors_done <= 16'd0;
                        busy         <= 1'b1;
                        // An empty request still produces a done pulse, with no rstart.
                        state        <= (num_sectors == 16'd0) ? S_FINISH : S_WAIT_SINK;
                    end
                end
                S_WAIT_SINK: begin
                    if (abort) begin
                        error    <= 1'b1;
                        err_code <= ERR_ABORT;
                        state    <= S_FINISH;
                    end else if (sink_ready && !rbusy) begin
                        // rbusy guards against a reader still draining an aborted sector.
                        rstart     <= 1'b1;
                        rsector_no <= cur_sector;
                        byte_cnt   <= 16'd0;
                        tmo_cnt    <= 32'd0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        rstart   <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_ABORT;
                        state    <= S_FINISH;
                    end else if (rdone) begin
                        rstart   <= 1'b0;
                        byte_cnt <= byte_now;
                        if (byte_now == SECTOR_BYTES_C) begin
                            sectors_done <= sectors_done + 16'd1;
                            cur_sector   <= cur_sector + 32'd1;
                            remaining    <= remaining - 16'd1;
                            gap_cnt      <= 16'd0;
                            state        <= (remaining == 16'd1) ? S_FINISH : S_GAP;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_COUNT;
                            state    <= S_FINISH;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        rstart   <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= S_FINISH;
                    end else begin
                        byte_cnt <= byte_now;
                        tmo_cnt  <= tmo_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        error    <= 1'b1;
                        err_code <= ERR_ABORT;
                        state    <= S_FINISH;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= S_WAIT_SINK;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_FINISH: begin
                    // busy falls in the same cycle that done is high.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
